// File: rtl/keypad_scanner_pkg.sv
// Shared constants and helpers for the 4x4 matrix keypad scanner.
package keypad_scanner_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;
  localparam int unsigned KP_KEYS = 16;

  // Key indices (row_idx*4 + col_idx) of the keys with a fixed role on the maze board.
  localparam int unsigned KEY_UP    = 1;
  localparam int unsigned KEY_LEFT  = 4;
  localparam int unsigned KEY_RIGHT = 6;
  localparam int unsigned KEY_DOWN  = 9;
  localparam int unsigned KEY_MAP   = 12;
  localparam int unsigned KEY_PAUSE = 15;

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic logic [3:0] lowest_key(input logic [KP_KEYS-1:0] map);
    logic [3:0] idx;
    idx = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (map[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kp_frame_debounce.sv
// Whole-frame debouncer: a new key map is accepted only after DEB_FRAMES identical frames.
module kp_frame_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = 5
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               frame_end,
  input  logic [KP_KEYS-1:0] frame,
  output logic [KP_KEYS-1:0] key_state,
  output logic [KP_KEYS-1:0] key_pulse
);

  localparam int unsigned CntW = $clog2(DEB_FRAMES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_FRAMES - 1);

  logic [KP_KEYS-1:0] last_frame_q, last_frame_d;
  logic [CntW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [KP_KEYS-1:0] key_state_q, key_state_d;
  logic [KP_KEYS-1:0] key_pulse_q, key_pulse_d;

  // Compare each completed frame and promote it once it has been stable long enough.
  always_comb begin
    last_frame_d = last_frame_q;
    stable_cnt_d = stable_cnt_q;
    key_state_d  = key_state_q;
    key_pulse_d  = '0;
    if (frame_end) begin
      if (frame != last_frame_q) begin
        last_frame_d = frame;
        stable_cnt_d = '0;
      end else begin
        if (stable_cnt_q != CntMax) stable_cnt_d = stable_cnt_q + CntW'(1);
        // Saturated count still qualifies, so a stable map that differs keeps updating.
        if (stable_cnt_d == CntMax && last_frame_q != key_state_q) begin
          key_state_d = last_frame_q;
          key_pulse_d = last_frame_q & ~key_state_q;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      last_frame_q <= '0;
      stable_cnt_q <= '0;
      key_state_q  <= '0;
      key_pulse_q  <= '0;
    end else begin
      last_frame_q <= last_frame_d;
      stable_cnt_q <= stable_cnt_d;
      key_state_q  <= key_state_d;
      key_pulse_q  <= key_pulse_d;
    end
  end

  assign key_state = key_state_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, frame capture and key event register.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_FRAMES = 5
) (
  input  logic               clk_in,
  input  logic               rst,
  output logic [KP_ROWS-1:0] row,
  input  logic [KP_COLS-1:0] col,
  output logic [KP_KEYS-1:0] key_state,
  output logic [KP_KEYS-1:0] key_pulse,
  output logic [3:0]         key_code,
  output logic               key_valid,
  input  logic               key_ack,
  output logic               overrun
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [DivW-1:0] DivSample = DivW'(SCAN_DIV - 2);

  logic [KP_COLS-1:0] col_meta_q, col_sync_q;
  logic [DivW-1:0]    div_cnt_q, div_cnt_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [KP_ROWS-1:0] row_q, row_d;
  logic [KP_KEYS-1:0] frame_q, frame_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               overrun_q, overrun_d;

  logic slot_end, sample, frame_end, ev;

  assign slot_end  = (div_cnt_q == DivLast);
  assign sample    = (div_cnt_q == DivSample);
  assign frame_end = slot_end && (row_idx_q == 2'd3);
  assign ev        = |key_pulse;

  // Two-flop synchronizer; idle (unpressed) columns read high.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  // Row slot timing, row advance and late-in-slot column capture into the frame buffer.
  always_comb begin
    div_cnt_d = div_cnt_q + DivW'(1);
    row_idx_d = row_idx_q;
    row_d     = row_q;
    frame_d   = frame_q;
    if (sample) frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
    if (slot_end) begin
      div_cnt_d = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_d     = ~(4'b0001 << row_idx_d);
    end
  end

  // Scan state registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      row_idx_q <= '0;
      row_q     <= 4'b1110;
      frame_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
      frame_q   <= frame_d;
    end
  end

  kp_frame_debounce #(
    .DEB_FRAMES(DEB_FRAMES)
  ) u_debounce (
    .clk_in   (clk_in),
    .rst      (rst),
    .frame_end(frame_end),
    .frame    (frame_q),
    .key_state(key_state),
    .key_pulse(key_pulse)
  );

  // One-deep event holding register; an ack in the same cycle frees the slot for the new event.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (ev && (!key_valid_q || key_ack)) begin
      key_code_d  = lowest_key(key_pulse);
      key_valid_d = 1'b1;
    end else if (!ev && key_ack) begin
      key_valid_d = 1'b0;
    end
    if (ev && key_valid_q && !key_ack) begin
      overrun_d = 1'b1;
    end else if (key_ack) begin
      overrun_d = 1'b0;
    end
  end

  // Event register state.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a switch-matrix model and a pulse scoreboard.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEB_FRAMES = 3;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_state;
  logic [15:0] key_pulse;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack;
  logic        overrun;

  logic [15:0] keys;          // physically closed switches
  logic [15:0] pulse_q[$];    // expected key_pulse words, in order
  logic [15:0] exp_pulse;
  logic [15:0] prev_pulse = '0;
  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  // Passive switch matrix: a closed switch pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_FRAMES(DEB_FRAMES)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_state(key_state),
    .key_pulse(key_pulse),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overrun  (overrun)
  );

  // Scoreboard: every nonzero pulse word must match the next expected one and last one cycle.
  always @(negedge clk_in) begin
    if (key_pulse !== 16'h0) begin
      vectors++;
      if (pulse_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse_unexpected got=%h want=none", key_pulse);
      end else begin
        exp_pulse = pulse_q.pop_front();
        if (key_pulse !== exp_pulse) begin
          miscompares++;
          $display("FAIL pulse_value got=%h want=%h", key_pulse, exp_pulse);
        end
      end
      vectors++;
      if (prev_pulse !== 16'h0) begin
        miscompares++;
        $display("FAIL pulse_width prev=%h want=0000", prev_pulse);
      end
    end
    prev_pulse = key_pulse;
  end

  task automatic wait_state(input logic [15:0] want, input int budget);
    int n;
    n = 0;
    while (key_state !== want && n < budget) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  task automatic ack_once();
    key_ack = 1'b1;
    @(negedge clk_in);
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    rst = 1'b0;
    keys = '0;
    key_ack = 1'b0;
    repeat (3) @(negedge clk_in);
    vectors++;
    if (row !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_row got=%b want=1110", row);
    end
    vectors++;
    if ({key_state, key_pulse, key_code, key_valid, overrun} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_outputs state=%h pulse=%h code=%h valid=%b ovr=%b want all 0",
               key_state, key_pulse, key_code, key_valid, overrun);
    end
    rst = 1'b1;
    for (int n = 0; n < 32; n++) begin
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      vectors++;
      if (row !== exp_row) begin
        miscompares++;
        $display("FAIL idle_row cycle=%0d got=%b want=%b", n, row, exp_row);
      end
      vectors++;
      if (key_state !== 16'h0 || key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cycle=%0d state=%h valid=%b want 0000/0", n, key_state,
                 key_valid);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_press6();
    keys = 16'h0040;
    pulse_q.push_back(16'h0040);
    wait_state(16'h0040, 100);
    vectors++;
    if (key_state !== 16'h0040) begin
      miscompares++;
      $display("FAIL press6_state got=%h want=0040", key_state);
    end
    @(negedge clk_in);
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL press6_event valid=%b code=%0d want 1/6", key_valid, key_code);
    end
    ack_once();
    vectors++;
    if (key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL press6_ack valid=%b want 0", key_valid);
    end
    keys = '0;
    wait_state(16'h0000, 100);
    vectors++;
    if (key_state !== 16'h0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release6 state=%h valid=%b want 0000/0", key_state, key_valid);
    end
  endtask

  task automatic test_bounce9();
    logic [3:0] last_row;
    logic       found;
    found = 1'b0;
    last_row = row;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_in);
      if (row == 4'b1110 && last_row == 4'b0111) found = 1'b1;
      last_row = row;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL bounce_align frame start not seen, row=%b want 1110", row);
    end
    // Toggle phase chosen so the row-2 sample never sees 3 consecutive equal pressed frames.
    repeat (6) @(negedge clk_in);
    for (int j = 0; j < 10; j++) begin
      keys = (j % 2 == 0) ? 16'h0200 : 16'h0000;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_in);
        vectors++;
        if (key_state !== 16'h0) begin
          miscompares++;
          $display("FAIL bounce_state step=%0d got=%h want=0000", j * 10 + k, key_state);
        end
      end
    end
    keys = '0;
    repeat (64) @(negedge clk_in);
    vectors++;
    if (key_state !== 16'h0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_settle state=%h valid=%b want 0000/0", key_state, key_valid);
    end
  endtask

  task automatic test_two_keys();
    keys = 16'h0012;
    pulse_q.push_back(16'h0012);
    wait_state(16'h0012, 100);
    vectors++;
    if (key_state !== 16'h0012) begin
      miscompares++;
      $display("FAIL two_state got=%h want=0012", key_state);
    end
    @(negedge clk_in);
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'd1) begin
      miscompares++;
      $display("FAIL two_event valid=%b code=%0d want 1/1", key_valid, key_code);
    end
    ack_once();
    keys = '0;
    wait_state(16'h0000, 100);
    vectors++;
    if (key_state !== 16'h0) begin
      miscompares++;
      $display("FAIL two_release got=%h want=0000", key_state);
    end
  endtask

  task automatic test_back_to_back();
    logic seen;
    keys = 16'h0040;
    pulse_q.push_back(16'h0040);
    wait_state(16'h0040, 100);
    @(negedge clk_in);
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'd6) begin
      miscompares++;
      $display("FAIL ovr_first valid=%b code=%0d want 1/6", key_valid, key_code);
    end
    keys = 16'h0240;
    pulse_q.push_back(16'h0200);
    wait_state(16'h0240, 100);
    @(negedge clk_in);
    vectors++;
    if (overrun !== 1'b1 || key_code !== 4'd6 || key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_drop ovr=%b code=%0d valid=%b want 1/6/1", overrun, key_code, key_valid);
    end
    ack_once();
    vectors++;
    if (key_valid !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear valid=%b ovr=%b want 0/0", key_valid, overrun);
    end
    keys = 16'h0242;
    pulse_q.push_back(16'h0002);
    wait_state(16'h0242, 100);
    @(negedge clk_in);
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'd1) begin
      miscompares++;
      $display("FAIL b2b_first valid=%b code=%0d want 1/1", key_valid, key_code);
    end
    keys = 16'h8242;
    pulse_q.push_back(16'h8000);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_in);
      if (key_pulse !== 16'h0) begin
        key_ack = 1'b1;
        seen = 1'b1;
      end
    end
    @(negedge clk_in);
    key_ack = 1'b0;
    vectors++;
    if (!seen || key_valid !== 1'b1 || key_code !== 4'd15 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ack_same seen=%b valid=%b code=%0d ovr=%b want 1/1/15/0", seen,
               key_valid, key_code, overrun);
    end
    ack_once();
    keys = '0;
    wait_state(16'h0000, 100);
    vectors++;
    if (key_state !== 16'h0 || key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release state=%h valid=%b want 0000/0", key_state, key_valid);
    end
  endtask

  task automatic test_reset_midframe();
    keys = 16'h0040;
    pulse_q.push_back(16'h0040);
    wait_state(16'h0040, 100);
    @(negedge clk_in);
    ack_once();
    repeat (5) @(negedge clk_in);
    rst = 1'b0;
    #1;
    vectors++;
    if (row !== 4'b1110 || {key_state, key_pulse, key_code, key_valid, overrun} !== 38'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs row=%b state=%h pulse=%h code=%h valid=%b ovr=%b",
               row, key_state, key_pulse, key_code, key_valid, overrun);
    end
    repeat (2) @(negedge clk_in);
    pulse_q.push_back(16'h0040);
    rst = 1'b1;
    repeat (47) @(negedge clk_in);
    vectors++;
    if (key_state !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_early got=%h want=0000", key_state);
    end
    @(negedge clk_in);
    vectors++;
    if (key_state !== 16'h0040) begin
      miscompares++;
      $display("FAIL midreset_third_frame got=%h want=0040", key_state);
    end
    @(negedge clk_in);
    ack_once();
    keys = '0;
    wait_state(16'h0000, 100);
  endtask

  initial begin
    test_reset();
    test_press6();
    test_bounce9();
    test_two_keys();
    test_back_to_back();
    test_reset_midframe();
    repeat (4) @(negedge clk_in);
    vectors++;
    if (pulse_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want=0", pulse_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
